tl_ul_client_arbiter: RTL

//  Shares one TL-UL manager port (A/D channels) between two TL-UL clients.
//  A: round-robin grant, held for every beat of a multi-beat Put; client index is prepended as the source MSB.
//  D: responses routed back by that MSB. Per-client in-flight limit throttles grants.

---
 rtl/tl_ul_pkg.sv | 66 ++++++
 rtl/tl_beat_counter.sv | 43 ++++
 rtl/tl_ul_client_arbiter_chk.sv | 30 +++
 rtl/tl_ul_client_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// -----------------------------------------------------------------------------
// tl_ul_pkg
// Purpose : Shared TL-UL opcode constants and beat-count helpers used by the
//           two-client arbiter and its beat counters.
// Contents: opcode localparams, BEAT_CNT_W, beats() for A-channel requests,
//           d_beats() for D-channel responses.
// -----------------------------------------------------------------------------
package tl_ul_pkg;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL          = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL       = 3'd1;
    localparam logic [2:0] OP_GET               = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK        = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA   = 3'd1;

    // Wide enough for 2^7 beats (largest size with single-byte beats)
    localparam int BEAT_CNT_W = 8;

    // Number of beats needed to move 2^size bytes over 2^lg_bytes-byte beats.
    function automatic logic [BEAT_CNT_W-1:0] beat_span(
        input logic [7:0] size,
        input logic [7:0] lg_bytes
    );
        logic [BEAT_CNT_W-1:0] n;
        if (size > lg_bytes) begin
            n = 8'd1 << (size - lg_bytes);
        end else begin
            n = 8'd1;
        end
        return n;
    endfunction

    // A-channel: only Puts carry data, so only Puts can span several beats.
    function automatic logic [BEAT_CNT_W-1:0] beats(
        input logic [2:0] opcode,
        input logic [7:0] size,
        input logic [7:0] lg_bytes
    );
        logic [BEAT_CNT_W-1:0] n;
        if ((opcode == OP_PUT_FULL) || (opcode == OP_PUT_PARTIAL)) begin
            n = beat_span(size, lg_bytes);
        end else begin
            n = 8'd1;
        end
        return n;
    endfunction

    // D-channel: only AccessAckData carries data.
    function automatic logic [BEAT_CNT_W-1:0] d_beats(
        input logic [2:0] opcode,
        input logic [7:0] size,
        input logic [7:0] lg_bytes
    );
        logic [BEAT_CNT_W-1:0] n;
        if (opcode == OP_ACCESS_ACK_DATA) begin
            n = beat_span(size, lg_bytes);
        end else begin
            n = 8'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// -----------------------------------------------------------------------------
// tl_beat_counter
// Purpose : Tracks position inside a (possibly multi-beat) TL-UL message.
// Ports   : clock, reset (sync, active-high)
//           i_fire   - a beat was transferred this cycle
//           i_beats  - total beats of the current message
//           o_first  - the next beat is the first of a message
//           o_last   - the next beat is the last of a message
// -----------------------------------------------------------------------------
module tl_beat_counter
    import tl_ul_pkg::*;
#(
    parameter int CNT_W = BEAT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_fire,
    input  logic [CNT_W-1:0] i_beats,
    output logic             o_first,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    assign o_first = (r_count == CNT_W'(0));
    assign o_last  = (r_count == (i_beats - CNT_W'(1)));

    // Beat index: wraps to zero after the last beat of each message
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= CNT_W'(0);
        end else if (i_fire) begin
            if (o_last) begin
                r_count <= CNT_W'(0);
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/tl_ul_client_arbiter_chk.sv
// -----------------------------------------------------------------------------
// tl_ul_client_arbiter_chk
// Purpose : Assertion-only companion of tl_ul_client_arbiter; a response may
//           only arrive for a client that has a request outstanding.
// Ports   : clock, reset, per-client in-flight count and D first/last fires.
// -----------------------------------------------------------------------------
module tl_ul_client_arbiter_chk #(
    parameter int IF_W = 3
) (
    input logic            clock,
    input logic            reset,
    input logic [IF_W-1:0] i_inflight0,
    input logic [IF_W-1:0] i_inflight1,
    input logic            i_d_first_fire0,
    input logic            i_d_first_fire1,
    input logic            i_d_last_fire0,
    input logic            i_d_last_fire1
);

    // In-flight counters must never be decremented (or a response started) at zero
    always @(posedge clock) begin
        if (!reset) begin
            assert (!((i_d_first_fire0 || i_d_last_fire0) && (i_inflight0 == IF_W'(0))))
                else $error("client 0 in-flight underflow");
            assert (!((i_d_first_fire1 || i_d_last_fire1) && (i_inflight1 == IF_W'(0))))
                else $error("client 1 in-flight underflow");
        end
    end

endmodule

// File: rtl/tl_ul_client_arbiter.sv
// -----------------------------------------------------------------------------
// tl_ul_client_arbiter
// Purpose : Shares one TL-UL manager port between two clients.
//           A: round-robin grant, held for all beats of a multi-beat Put;
//              client index becomes the manager source MSB.
//           D: routed back by source MSB, MSB stripped.
//           Per-client in-flight limit throttles A grants.
// Ports   : clock, reset (sync, active-high)
//           c0_a_* / c1_a_*  client A channels (valid/ready + fields)
//           c0_d_* / c1_d_*  client D channels
//           m_a_*            manager A channel, m_a_source = {grant, source}
//           m_d_*            manager D channel
// -----------------------------------------------------------------------------
module tl_ul_client_arbiter
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int SIZE_W       = 3,
    parameter int SRC_W        = 3,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clock,
    input  logic                reset,
    // client 0 A
    input  logic                c0_a_valid,
    output logic                c0_a_ready,
    input  logic [2:0]          c0_a_opcode,
    input  logic [2:0]          c0_a_param,
    input  logic [SIZE_W-1:0]   c0_a_size,
    input  logic [SRC_W-1:0]    c0_a_source,
    input  logic [ADDR_W-1:0]   c0_a_address,
    input  logic [DATA_W/8-1:0] c0_a_mask,
    input  logic [DATA_W-1:0]   c0_a_data,
    // client 0 D
    output logic                c0_d_valid,
    input  logic                c0_d_ready,
    output logic [2:0]          c0_d_opcode,
    output logic [1:0]          c0_d_param,
    output logic [SIZE_W-1:0]   c0_d_size,
    output logic [SRC_W-1:0]    c0_d_source,
    output logic                c0_d_denied,
    output logic                c0_d_corrupt,
    output logic [DATA_W-1:0]   c0_d_data,
    // client 1 A
    input  logic                c1_a_valid,
    output logic                c1_a_ready,
    input  logic [2:0]          c1_a_opcode,
    input  logic [2:0]          c1_a_param,
    input  logic [SIZE_W-1:0]   c1_a_size,
    input  logic [SRC_W-1:0]    c1_a_source,
    input  logic [ADDR_W-1:0]   c1_a_address,
    input  logic [DATA_W/8-1:0] c1_a_mask,
    input  logic [DATA_W-1:0]   c1_a_data,
    // client 1 D
    output logic                c1_d_valid,
    input  logic                c1_d_ready,
    output logic [2:0]          c1_d_opcode,
    output logic [1:0]          c1_d_param,
    output logic [SIZE_W-1:0]   c1_d_size,
    output logic [SRC_W-1:0]    c1_d_source,
    output logic                c1_d_denied,
    output logic                c1_d_corrupt,
    output logic [DATA_W-1:0]   c1_d_data,
    // manager A
    output logic                m_a_valid,
    input  logic                m_a_ready,
    output logic [2:0]          m_a_opcode,
    output logic [2:0]          m_a_param,
    output logic [SIZE_W-1:0]   m_a_size,
    output logic [SRC_W:0]      m_a_source,
    output logic [ADDR_W-1:0]   m_a_address,
    output logic [DATA_W/8-1:0] m_a_mask,
    output logic [DATA_W-1:0]   m_a_data,
    // manager D
    input  logic                m_d_valid,
    output logic                m_d_ready,
    input  logic [2:0]          m_d_opcode,
    input  logic [1:0]          m_d_param,
    input  logic [SIZE_W-1:0]   m_d_size,
    input  logic [SRC_W:0]      m_d_source,
    input  logic                m_d_denied,
    input  logic                m_d_corrupt,
    input  logic [DATA_W-1:0]   m_d_data
);

    localparam int              IF_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IF_W-1:0] IF_MAX = IF_W'(MAX_INFLIGHT);
    localparam logic [7:0]      LG_B   = 8'($clog2(DATA_W / 8));

    logic            r_rr_ptr;      // preferred client when both are eligible
    logic            r_locked;      // mid-burst: grant frozen
    logic            r_lock_idx;    // client owning the burst
    logic [IF_W-1:0] r_inflight0;
    logic [IF_W-1:0] r_inflight1;

    logic                  w_elig0, w_elig1, w_grant, w_grant_elig;
    logic                  w_a_fire, w_a_first, w_a_last, w_a_last_fire;
    logic [BEAT_CNT_W-1:0] w_a_beats, w_d_beats;
    logic                  w_d_sel;
    logic                  w_d_fire0, w_d_fire1;
    logic                  w_d_first0, w_d_first1, w_d_last0, w_d_last1;
    logic                  w_d_last_fire0, w_d_last_fire1;
    logic                  w_inc0, w_inc1;

    // ---------------- A channel ----------------
    assign w_elig0 = c0_a_valid && (r_inflight0 < IF_MAX);
    assign w_elig1 = c1_a_valid && (r_inflight1 < IF_MAX);

    // Grant selection: frozen while locked, otherwise round-robin among eligible
    always_comb begin
        w_grant = r_rr_ptr;
        if (r_locked) begin
            w_grant = r_lock_idx;
        end else if (w_elig0 && w_elig1) begin
            w_grant = r_rr_ptr;
        end else if (w_elig1) begin
            w_grant = 1'b1;
        end else if (w_elig0) begin
            w_grant = 1'b0;
        end else begin
            w_grant = r_rr_ptr;
        end
    end

    assign w_grant_elig = w_grant ? w_elig1 : w_elig0;
    assign m_a_valid    = !reset && w_grant_elig;
    assign c0_a_ready   = !reset && m_a_ready && !w_grant && w_elig0;
    assign c1_a_ready   = !reset && m_a_ready &&  w_grant && w_elig1;
    assign w_a_fire     = m_a_valid && m_a_ready;

    // A field mux from the granted client
    always_comb begin
        m_a_opcode  = c0_a_opcode;
        m_a_param   = c0_a_param;
        m_a_size    = c0_a_size;
        m_a_source  = {1'b0, c0_a_source};
        m_a_address = c0_a_address;
        m_a_mask    = c0_a_mask;
        m_a_data    = c0_a_data;
        if (w_grant) begin
            m_a_opcode  = c1_a_opcode;
            m_a_param   = c1_a_param;
            m_a_size    = c1_a_size;
            m_a_source  = {1'b1, c1_a_source};
            m_a_address = c1_a_address;
            m_a_mask    = c1_a_mask;
            m_a_data    = c1_a_data;
        end else begin
            m_a_source  = {1'b0, c0_a_source};
        end
    end

    assign w_a_beats = beats(m_a_opcode, 8'(m_a_size), LG_B);

    tl_beat_counter u_a_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_fire  (w_a_fire),
        .i_beats (w_a_beats),
        .o_first (w_a_first),
        .o_last  (w_a_last)
    );

    assign w_a_last_fire = w_a_fire && w_a_last;

    // Burst lock and round-robin pointer; pointer moves only when a message completes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_locked   <= 1'b0;
            r_lock_idx <= 1'b0;
            r_rr_ptr   <= 1'b0;
        end else if (w_a_fire) begin
            if (w_a_last) begin
                r_locked <= 1'b0;
                r_rr_ptr <= ~w_grant;
            end else if (w_a_first) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_grant;
            end else begin
                r_locked <= r_locked;
            end
        end else begin
            r_locked <= r_locked;
        end
    end

    // ---------------- D channel ----------------
    assign w_d_sel    = m_d_source[SRC_W];
    assign c0_d_valid = !reset && m_d_valid && !w_d_sel;
    assign c1_d_valid = !reset && m_d_valid &&  w_d_sel;
    assign m_d_ready  = !reset && (w_d_sel ? c1_d_ready : c0_d_ready);

    assign c0_d_opcode  = m_d_opcode;
    assign c0_d_param   = m_d_param;
    assign c0_d_size    = m_d_size;
    assign c0_d_source  = m_d_source[SRC_W-1:0];
    assign c0_d_denied  = m_d_denied;
    assign c0_d_corrupt = m_d_corrupt;
    assign c0_d_data    = m_d_data;
    assign c1_d_opcode  = m_d_opcode;
    assign c1_d_param   = m_d_param;
    assign c1_d_size    = m_d_size;
    assign c1_d_source  = m_d_source[SRC_W-1:0];
    assign c1_d_denied  = m_d_denied;
    assign c1_d_corrupt = m_d_corrupt;
    assign c1_d_data    = m_d_data;

    assign w_d_beats = d_beats(m_d_opcode, 8'(m_d_size), LG_B);
    assign w_d_fire0 = c0_d_valid && c0_d_ready;
    assign w_d_fire1 = c1_d_valid && c1_d_ready;

    // Each client keeps its own response position; D beats never interleave per client
    tl_beat_counter u_d0_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_fire  (w_d_fire0),
        .i_beats (w_d_beats),
        .o_first (w_d_first0),
        .o_last  (w_d_last0)
    );

    tl_beat_counter u_d1_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_fire  (w_d_fire1),
        .i_beats (w_d_beats),
        .o_first (w_d_first1),
        .o_last  (w_d_last1)
    );

    assign w_d_last_fire0 = w_d_fire0 && w_d_last0;
    assign w_d_last_fire1 = w_d_fire1 && w_d_last1;
    assign w_inc0         = w_a_last_fire && !w_grant;
    assign w_inc1         = w_a_last_fire &&  w_grant;

    // In-flight accounting: request completion +1, response completion -1
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight0 <= IF_W'(0);
            r_inflight1 <= IF_W'(0);
        end else begin
            if (w_inc0 && !w_d_last_fire0) begin
                r_inflight0 <= r_inflight0 + IF_W'(1);
            end else if (w_d_last_fire0 && !w_inc0) begin
                r_inflight0 <= r_inflight0 - IF_W'(1);
            end else begin
                r_inflight0 <= r_inflight0;
            end
            if (w_inc1 && !w_d_last_fire1) begin
                r_inflight1 <= r_inflight1 + IF_W'(1);
            end else if (w_d_last_fire1 && !w_inc1) begin
                r_inflight1 <= r_inflight1 - IF_W'(1);
            end else begin
                r_inflight1 <= r_inflight1;
            end
        end
    end

    tl_ul_client_arbiter_chk #(.IF_W(IF_W)) u_chk (
        .clock           (clock),
        .reset           (reset),
        .i_inflight0     (r_inflight0),
        .i_inflight1     (r_inflight1),
        .i_d_first_fire0 (w_d_fire0 && w_d_first0),
        .i_d_first_fire1 (w_d_fire1 && w_d_first1),
        .i_d_last_fire0  (w_d_last_fire0),
        .i_d_last_fire1  (w_d_last_fire1)
    );

endmodule
